output_limit_fifo: RTL and testbench
====================================

OUTPUT_LIMIT_FIFO -- requirements
Module: output_limit_fifo

Interface
REQ-001 SHALL have parameter ADDR_MSB, default 12; FIFO depth = 2^(ADDR_MSB+1) 16-bit words (8192 by default).
REQ-002 SHALL have port IFCLK, input, 1 bit; the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-004 SHALL have ports din, input, 16 bits, and wr_en, input, 1 bit; the write side from the application.
REQ-005 SHALL have port full, output, 1 bit; high when the FIFO holds depth words.
REQ-006 SHALL have ports dout, output, 16 bits; empty, output, 1 bit; rd_en, input, 1 bit; the first-word-fall-through read side toward the high-speed output.
REQ-007 SHALL have port mode_limit, input, 1 bit; 1 = limited output mode, 0 = free flow.
REQ-008 SHALL have port reg_output_limit, input, 1 bit; single-cycle request to register a new limit.
REQ-009 SHALL have port output_limit, output, 16 bits; the last registered limit, read back by the host over the command interface.
REQ-010 SHALL have port output_limit_not_done, output, 1 bit; high while registered words remain unread.
REQ-011 SHALL have port err_overflow, output, 1 bit; sticky write-while-full flag.

Function
REQ-012 count SHALL equal words written minus words popped; width ADDR_MSB+2; range 0..depth.
REQ-013 A write SHALL occur iff wr_en && !full; the word is stored and count increments.
REQ-014 A write with wr_en && full SHALL drop the word, leave count unchanged and set err_overflow, which stays high until rst.
REQ-015 A pop SHALL occur iff rd_en && !empty; dout SHALL advance to the next word on the following cycle.
REQ-016 FWFT latency: a word written into an otherwise empty FIFO at edge N SHALL appear on dout with raw-empty low after edge N+2.
REQ-017 A simultaneous write and pop SHALL both take effect, including when full or when one word remains; count is then unchanged.
REQ-018 Read/write pointers SHALL wrap modulo depth; full/empty SHALL be derived from count, never from pointer equality alone.
REQ-019 Limit FSM states: IDLE, SENDING; the remaining-word counter is 16 bits.
REQ-020 In IDLE with mode_limit=1, a reg_output_limit pulse SHALL set output_limit = min(count, 65535), sampled before the same-cycle write or pop, and set remaining to the same value.
REQ-021 On that pulse, the FSM SHALL go to SENDING if the value is nonzero, otherwise stay in IDLE.
REQ-022 reg_output_limit pulses in SENDING, or while mode_limit=0, SHALL be ignored; output_limit is unchanged.
REQ-023 In SENDING, each pop SHALL decrement remaining; the pop that makes remaining 0 SHALL return the FSM to IDLE on the same edge.
REQ-024 Output empty = raw_empty OR (mode_limit AND state==IDLE) OR (mode_limit AND remaining==0).
REQ-025 output_limit_not_done SHALL equal (state==SENDING), registered.
REQ-026 If mode_limit falls during SENDING, the FSM SHALL go to IDLE and remaining to 0 on the next edge; free flow begins; output_limit holds its value.
REQ-027 mode_limit=0 SHALL NOT gate empty; FIFO contents are unaffected by mode changes.

Reset
REQ-028 While rst is high: pointers=0, count=0, full=0, empty=1, output_limit=0, remaining=0, FSM=IDLE, output_limit_not_done=0, err_overflow=0, dout=0.
REQ-029 Reset SHALL apply asynchronously; a transfer in progress is abandoned and FIFO contents are discarded.
REQ-030 After rst deasserts, the first write SHALL be accepted on the first IFCLK edge.

Verification
REQ-031 mode_limit=0; write 0x0001..0x0005; pop all -> dout sequence 1..5 in order; empty high after the fifth pop; output_limit_not_done stays 0.
REQ-032 mode_limit=1; write 10 words; pulse reg_output_limit -> output_limit=10, not_done=1; after 10 pops not_done=0 and empty=1.
REQ-033 mode_limit=1; write 4 words; pulse reg_output_limit in the same cycle as the 5th write -> output_limit=4; 4 pops allowed, then empty=1 with count=1; a second pulse -> output_limit=1.
REQ-034 Fill to depth, then wr_en 1 cycle more -> full=1, err_overflow=1, count=depth; simultaneous pop+write at full -> count stays depth, err_overflow stays 1.
REQ-035 SENDING with remaining=3; drop mode_limit -> FSM IDLE, not_done=0, all words drain freely; output_limit still 3.
REQ-036 Assert rst mid-SENDING with 100 words queued -> all outputs at reset values immediately (before the next IFCLK edge); after release, written word 0xABCD is the first dout.

Source files
------------

// File: rtl/output_limit_fifo.sv
// First-word-fall-through FIFO with an optional output limiter.
// In limited mode only a host-registered number of words can be popped.
module output_limit_fifo #(
  parameter int ADDR_MSB = 12
) (
  input  logic        IFCLK,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        empty,
  input  logic        rd_en,
  input  logic        mode_limit,
  input  logic        reg_output_limit,
  output logic [15:0] output_limit,
  output logic        output_limit_not_done,
  output logic        err_overflow
);

  localparam int AW    = ADDR_MSB + 1;
  localparam int CW    = ADDR_MSB + 2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, SENDING} state_t;

  logic [15:0]   mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] avail_reg, avail_next;
  logic          wr_vis_reg;
  logic          dout_valid_reg, dout_valid_next;
  logic [15:0]   dout_reg;
  logic          err_reg;
  state_t        state_reg, state_next;
  logic [15:0]   remaining_reg, remaining_next;
  logic [15:0]   limit_reg, limit_next;
  logic [31:0]   count_ext;
  logic [15:0]   limit_sat;
  logic          do_write, do_pop, do_fetch;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = !dout_valid_reg
               | (mode_limit & (state_reg == IDLE))
               | (mode_limit & (remaining_reg == 16'd0));

  assign do_pop   = rd_en & !empty;
  // A pop frees a slot in the same cycle, so a write at full still lands.
  assign do_write = wr_en & (!full | do_pop);
  // avail_reg counts stored words the read side may fetch; a new word joins
  // it one cycle after being written, giving the two-edge fall-through.
  assign do_fetch = (avail_reg != '0) & (!dout_valid_reg | do_pop);

  assign count_next = count_reg + CW'(do_write) - CW'(do_pop);
  assign avail_next = avail_reg + CW'(wr_vis_reg) - CW'(do_fetch);

  always_comb begin
    dout_valid_next = dout_valid_reg;
    if (do_fetch)
      dout_valid_next = 1'b1;
    else if (do_pop)
      dout_valid_next = 1'b0;
  end

  assign count_ext = 32'(count_reg);
  assign limit_sat = (count_ext > 32'h0000_FFFF) ? 16'hFFFF : count_ext[15:0];

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    limit_next     = limit_reg;
    if (!mode_limit) begin
      state_next     = IDLE;
      remaining_next = 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (reg_output_limit) begin
            limit_next     = limit_sat;
            remaining_next = limit_sat;
            state_next     = (limit_sat != 16'd0) ? SENDING : IDLE;
          end
        end
        SENDING: begin
          if (do_pop) begin
            remaining_next = remaining_reg - 16'd1;
            if (remaining_reg == 16'd1)
              state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge IFCLK) begin
    if (do_write)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge IFCLK or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      avail_reg      <= '0;
      wr_vis_reg     <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_reg       <= 16'd0;
      err_reg        <= 1'b0;
      state_reg      <= IDLE;
      remaining_reg  <= 16'd0;
      limit_reg      <= 16'd0;
    end else begin
      if (do_write)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_fetch) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dout_reg   <= mem[rd_ptr_reg];
      end
      if (wr_en & !do_write)
        err_reg <= 1'b1;
      count_reg      <= count_next;
      avail_reg      <= avail_next;
      wr_vis_reg     <= do_write;
      dout_valid_reg <= dout_valid_next;
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      limit_reg      <= limit_next;
    end
  end

  assign dout                  = dout_reg;
  assign err_overflow          = err_reg;
  assign output_limit          = limit_reg;
  assign output_limit_not_done = (state_reg == SENDING);

endmodule

// File: tb/tb_output_limit_fifo.sv
// Directed bench for output_limit_fifo: a scoreboard queue holds written words,
// a negedge monitor compares dout against it on every pop.
module tb_output_limit_fifo;

  localparam int ADDR_MSB = 6;
  localparam int DEPTH    = 1 << (ADDR_MSB + 1);

  logic        IFCLK = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'd0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        mode_limit = 1'b0;
  logic        reg_output_limit = 1'b0;
  logic        full, empty, output_limit_not_done, err_overflow;
  logic [15:0] dout, output_limit;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb_q[$];

  output_limit_fifo #(.ADDR_MSB(ADDR_MSB)) dut (
    .IFCLK(IFCLK), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .dout(dout), .empty(empty), .rd_en(rd_en), .mode_limit(mode_limit),
    .reg_output_limit(reg_output_limit), .output_limit(output_limit),
    .output_limit_not_done(output_limit_not_done), .err_overflow(err_overflow)
  );

  always #5 IFCLK = ~IFCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A pop happens at the next posedge whenever rd_en && !empty now.
  always @(negedge IFCLK) begin
    if (!rst && rd_en && !empty) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got dout 0x%04h expected no pop", dout);
      end else begin
        logic [15:0] exp_w;
        exp_w = sb_q.pop_front();
        $display("[TB] pop dout=0x%04h exp=0x%04h", dout, exp_w);
        if (dout !== exp_w) begin
          fails++;
          $display("FAIL pop_data: got 0x%04h expected 0x%04h", dout, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge IFCLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    din = d;
    wr_en = 1'b1;
    sb_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop(input string name);
    chk(name, {31'd0, empty}, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_limit();
    reg_output_limit = 1'b1;
    tick();
    reg_output_limit = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_limit"}, {16'd0, output_limit}, 32'd0);
    chk({tag, "_notdone"}, {31'd0, output_limit_not_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_overflow}, 32'd0);
    chk({tag, "_dout"}, {16'd0, dout}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Free flow, fall-through latency and ordering
    mode_limit = 1'b0;
    wr(16'h0001);
    tick();
    chk("fwft_n1_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("fwft_n2_empty", {31'd0, empty}, 32'd0);
    chk("fwft_n2_dout", {16'd0, dout}, 32'h0001);
    for (int i = 2; i <= 5; i++) wr(16'(i));
    tick(); tick();
    for (int i = 0; i < 5; i++) pop("free_pop_ready");
    chk("free_empty_after", {31'd0, empty}, 32'd1);
    chk("free_notdone", {31'd0, output_limit_not_done}, 32'd0);

    // Limited mode: 10 words
    mode_limit = 1'b1;
    for (int i = 0; i < 10; i++) wr(16'h0010 + 16'(i));
    tick(); tick();
    chk("lim_idle_gated", {31'd0, empty}, 32'd1);
    pulse_limit();
    chk("lim10_value", {16'd0, output_limit}, 32'd10);
    chk("lim10_notdone", {31'd0, output_limit_not_done}, 32'd1);
    for (int i = 0; i < 10; i++) pop("lim10_pop_ready");
    chk("lim10_notdone_end", {31'd0, output_limit_not_done}, 32'd0);
    chk("lim10_empty_end", {31'd0, empty}, 32'd1);

    // Limit sampled before the same-cycle write
    for (int i = 0; i < 4; i++) wr(16'h0020 + 16'(i));
    din = 16'h0024;
    wr_en = 1'b1;
    reg_output_limit = 1'b1;
    sb_q.push_back(16'h0024);
    tick();
    wr_en = 1'b0;
    reg_output_limit = 1'b0;
    chk("lim4_value", {16'd0, output_limit}, 32'd4);
    tick(); tick();
    for (int i = 0; i < 4; i++) pop("lim4_pop_ready");
    chk("lim4_empty_end", {31'd0, empty}, 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    pulse_limit();
    chk("lim1_value", {16'd0, output_limit}, 32'd1);
    chk("lim1_notdone", {31'd0, output_limit_not_done}, 32'd1);
    pop("lim1_pop_ready");
    chk("lim1_empty_end", {31'd0, empty}, 32'd1);

    // Dropping mode_limit mid-transfer
    for (int i = 0; i < 3; i++) wr(16'h0030 + 16'(i));
    tick(); tick();
    pulse_limit();
    chk("lim3_value", {16'd0, output_limit}, 32'd3);
    mode_limit = 1'b0;
    tick();
    chk("drop_notdone", {31'd0, output_limit_not_done}, 32'd0);
    pulse_limit();
    chk("drop_pulse_ignored", {16'd0, output_limit}, 32'd3);
    for (int i = 0; i < 3; i++) pop("drop_pop_ready");
    chk("drop_empty_end", {31'd0, empty}, 32'd1);
    chk("drop_limit_held", {16'd0, output_limit}, 32'd3);

    // Fill to depth, overflow, pop+write at full
    for (int i = 0; i < DEPTH; i++) wr(16'h0100 + 16'(i));
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_err_clear", {31'd0, err_overflow}, 32'd0);
    din = 16'hDEAD;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("ovf_err", {31'd0, err_overflow}, 32'd1);
    chk("ovf_full", {31'd0, full}, 32'd1);
    din = 16'h0BEE;
    wr_en = 1'b1;
    rd_en = 1'b1;
    sb_q.push_back(16'h0BEE);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("fullrw_full", {31'd0, full}, 32'd1);
    chk("fullrw_err", {31'd0, err_overflow}, 32'd1);
    tick(); tick();
    for (int i = 0; i < DEPTH; i++) pop("drain_pop_ready");
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_full", {31'd0, full}, 32'd0);
    chk("drain_sb_size", sb_q.size(), 32'd0);

    // Asynchronous reset mid-SENDING
    mode_limit = 1'b1;
    for (int i = 0; i < 100; i++) wr(16'h0200 + 16'(i));
    tick(); tick();
    pulse_limit();
    chk("lim100_value", {16'd0, output_limit}, 32'd100);
    pop("lim100_pop_ready");
    pop("lim100_pop_ready");
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk_reset_outputs("async_rst");
    #2;
    rst = 1'b0;
    mode_limit = 1'b0;
    wr(16'hABCD);
    tick(); tick();
    chk("post_rst_dout", {16'd0, dout}, 32'h0000ABCD);
    pop("post_rst_pop_ready");
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_sb_size", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
